// File: rtl/drink_pkg.sv
// Shared types and constants for the coin front end and the vending machine.
package drink_pkg;

  // Two-bit coin code carried on the coin bus.
  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NONE   = 2'b00;
  localparam coin_code_t COIN_NICKEL = 2'b01;
  localparam coin_code_t COIN_DIME   = 2'b10;

  // Transmit FSM states: wait for a coin, show it for one cycle, then idle the bus.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Synchroniser and debouncer for one raw coin-slot sensor. Emits a single
// one-cycle pulse per high period that lasts at least DEBOUNCE_CYCLES
// synchronised samples.
module coin_debounce
  import drink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic event_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;
  logic          reached;
  logic          at_target;

  assign at_target = (count == TARGET);

  // Two-flop synchroniser for the asynchronous pad, then a saturating run-length
  // counter; the pulse fires on the first cycle the counter sits at its target,
  // and 'reached' suppresses repeats for the rest of the same high period.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      count       <= '0;
      reached     <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!sync2) begin
        count <= '0;
      end else if (!at_target) begin
        count <= count + 1'b1;
      end
      reached     <= at_target;
      event_pulse <= at_target && !reached;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces the nickel and dime sensors, buffers accepted
// coins in a small FIFO and replays each one as a single-cycle code on 'coin',
// separated by idle cycles, for the vending machine FSM.
module coin_acceptor
  import drink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nickel_sense,
  input  logic       dime_sense,
  input  logic       hold,
  output logic [1:0] coin,
  output logic       coin_reject,
  output logic       fifo_empty,
  output logic [7:0] accepted_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic          nickel_event;
  logic          dime_event;
  logic          any_event;
  coin_code_t    push_code;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  coin_code_t    fifo_mem [FIFO_DEPTH];
  coin_code_t    head_code;
  tx_state_t     state;
  logic [GW-1:0] gap_count;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_nickel_debounce (
    .clock       (clock),
    .reset       (reset),
    .raw         (nickel_sense),
    .event_pulse (nickel_event)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dime_debounce (
    .clock       (clock),
    .reset       (reset),
    .raw         (dime_sense),
    .event_pulse (dime_event)
  );

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
  // differ only in the wrap bit mean full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_code  = fifo_mem[rd_ptr[AW-1:0]];

  // A pop only happens from IDLE when the vending machine is not busy.
  assign pop = (state == IDLE) && !fifo_empty && !hold;

  // The dime wins when both sensors fire together; a same-cycle pop frees a
  // slot, so a full FIFO still accepts the coin in that case.
  assign any_event   = nickel_event || dime_event;
  assign push_code   = dime_event ? COIN_DIME : COIN_NICKEL;
  assign push        = any_event && (!fifo_full || pop);
  assign coin_reject = (nickel_event && dime_event) || (any_event && !push);

  // FIFO pointer bookkeeping; reset discards everything buffered.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are meaningless until the write pointer covers them.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= push_code;
    end
  end

  // Transmit FSM: load the head code on the pop edge so it is visible for the
  // whole DRIVE cycle, count it on leaving DRIVE, then hold the bus at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      coin           <= COIN_NONE;
      gap_count      <= '0;
      accepted_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          coin <= COIN_NONE;
          if (pop) begin
            coin  <= head_code;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          coin           <= COIN_NONE;
          accepted_count <= accepted_count + 8'd1;
          gap_count      <= '0;
          state          <= GAP;
        end
        GAP: begin
          coin <= COIN_NONE;
          if (gap_count == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_count <= gap_count + 1'b1;
          end
        end
        default: begin
          coin  <= COIN_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: a scoreboard queue holds the codes
// expected on 'coin', filled as sensor pulses are driven and drained by a
// monitor as codes appear.
module tb_coin_acceptor;
  import drink_pkg::*;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int FIFO_DEPTH      = 4;
  localparam int GAP_CYCLES      = 1;
  localparam int LATENCY         = 1 + 2 + DEBOUNCE_CYCLES + 2;
  localparam int PERIOD          = 1 + GAP_CYCLES + 1;

  logic       clock;
  logic       reset;
  logic       nickel_sense;
  logic       dime_sense;
  logic       hold;
  logic [1:0] coin;
  logic       coin_reject;
  logic       fifo_empty;
  logic [7:0] accepted_count;

  int         checks;
  int         errors;
  int         cyc;
  int         rejects_seen;
  int         exp_rejects;
  int         first_code_cyc;
  int         last_code_cyc;
  int         last_rise_cyc;
  bit         spacing_on;
  logic [1:0] prev_code;
  logic [1:0] sb[$];

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .GAP_CYCLES     (GAP_CYCLES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .nickel_sense   (nickel_sense),
    .dime_sense     (dime_sense),
    .hold           (hold),
    .coin           (coin),
    .coin_reject    (coin_reject),
    .fifo_empty     (fifo_empty),
    .accepted_count (accepted_count)
  );

  // 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Edge counter used for latency and spacing measurements.
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Hard stop in case something wedges the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Drives one sensor pulse of 'len' cycles, records its expected code and
  // reject count, then leaves the sensors low long enough to re-arm.
  task automatic applyStimulus(input logic nick, input logic dime, input int len,
                               input logic [1:0] exp_code, input int exp_rej);
    @(posedge clock);
    #1;
    nickel_sense  = nick;
    dime_sense    = dime;
    last_rise_cyc = cyc;
    if (exp_code != COIN_NONE) sb.push_back(exp_code);
    exp_rejects += exp_rej;
    repeat (len) @(posedge clock);
    #1;
    nickel_sense = 1'b0;
    dime_sense   = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every code must be expected, last one cycle, be legal, and (when
  // enabled) follow the previous code by exactly one DRIVE+GAP+IDLE period.
  always @(negedge clock) begin
    if (!reset) begin
      if (prev_code != COIN_NONE) checkOutput("code width", coin, COIN_NONE);
      if (coin == 2'b11) checkOutput("illegal code", coin, COIN_NONE);
      if (coin != COIN_NONE) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected code", coin, COIN_NONE);
        end else begin
          checkOutput("code value", coin, sb.pop_front());
        end
        if (first_code_cyc < 0) first_code_cyc = cyc;
        if (spacing_on && last_code_cyc >= 0) checkOutput("code spacing", cyc - last_code_cyc, PERIOD);
        last_code_cyc = cyc;
      end
      if (coin_reject) rejects_seen++;
    end
    prev_code = coin;
  end

  initial begin
    int base_count;
    int base_rej;
    bit got_code;

    checks         = 0;
    errors         = 0;
    rejects_seen   = 0;
    exp_rejects    = 0;
    first_code_cyc = -1;
    last_code_cyc  = -1;
    last_rise_cyc  = 0;
    spacing_on     = 1'b0;
    prev_code      = COIN_NONE;
    reset          = 1'b1;
    nickel_sense   = 1'b0;
    dime_sense     = 1'b0;
    hold           = 1'b0;

    // Reset state.
    waitCycles(3);
    checkOutput("reset coin", coin, COIN_NONE);
    checkOutput("reset reject", coin_reject, 0);
    checkOutput("reset empty", fifo_empty, 1);
    checkOutput("reset count", accepted_count, 0);
    reset = 1'b0;

    // Single nickel: latency, count and no rejects.
    $display("[TB] single nickel");
    applyStimulus(1'b1, 1'b0, 10, COIN_NICKEL, 0);
    waitCycles(20);
    checkOutput("nickel latency", first_code_cyc - last_rise_cyc, LATENCY);
    checkOutput("nickel count", accepted_count, 1);
    checkOutput("nickel rejects", rejects_seen, exp_rejects);
    checkOutput("nickel drained", sb.size(), 0);

    // Glitch shorter than the debounce window.
    $display("[TB] glitch");
    applyStimulus(1'b0, 1'b1, DEBOUNCE_CYCLES - 1, COIN_NONE, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput("glitch empty", fifo_empty, 1);
    end
    checkOutput("glitch count", accepted_count, 1);

    // Burst under hold: fill the FIFO, the extra dime is rejected.
    $display("[TB] burst with hold");
    hold     = 1'b1;
    base_rej = rejects_seen;
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(1'b0, 1'b1, 6, COIN_DIME, 0);
    applyStimulus(1'b0, 1'b1, 6, COIN_NONE, 1);
    waitCycles(10);
    checkOutput("burst reject", rejects_seen - base_rej, 1);
    checkOutput("burst not empty", fifo_empty, 0);
    checkOutput("burst held count", accepted_count, 1);
    last_code_cyc = -1;
    spacing_on    = 1'b1;
    hold          = 1'b0;
    waitCycles(25);
    spacing_on = 1'b0;
    checkOutput("burst count", accepted_count, 1 + FIFO_DEPTH);
    checkOutput("burst drained", sb.size(), 0);
    checkOutput("burst empty", fifo_empty, 1);

    // Simultaneous nickel and dime: dime delivered, nickel rejected.
    $display("[TB] simultaneous");
    base_count = accepted_count;
    base_rej   = rejects_seen;
    applyStimulus(1'b1, 1'b1, 6, COIN_DIME, 1);
    waitCycles(15);
    checkOutput("simul reject", rejects_seen - base_rej, 1);
    checkOutput("simul count", accepted_count, base_count + 1);
    checkOutput("simul drained", sb.size(), 0);

    // Reset while a coin is in DRIVE with more queued behind it.
    $display("[TB] reset mid-operation");
    hold = 1'b1;
    applyStimulus(1'b1, 1'b0, 6, COIN_NICKEL, 0);
    applyStimulus(1'b0, 1'b1, 6, COIN_DIME, 0);
    applyStimulus(1'b1, 1'b0, 6, COIN_NICKEL, 0);
    waitCycles(8);
    hold     = 1'b0;
    got_code = 1'b0;
    for (int i = 0; i < 50 && !got_code; i++) begin
      @(negedge clock);
      if (coin != COIN_NONE) got_code = 1'b1;
    end
    checkOutput("reset wait code", got_code, 1);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    checkOutput("midreset coin", coin, COIN_NONE);
    checkOutput("midreset empty", fifo_empty, 1);
    checkOutput("midreset count", accepted_count, 0);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(30);
    checkOutput("postreset count", accepted_count, 0);
    checkOutput("postreset empty", fifo_empty, 1);

    // Counter wrap: 257 nickels leave the count at 1.
    $display("[TB] wrap");
    for (int i = 0; i < 257; i++) applyStimulus(1'b1, 1'b0, 5, COIN_NICKEL, 0);
    waitCycles(20);
    checkOutput("wrap count", accepted_count, 1);
    checkOutput("wrap drained", sb.size(), 0);
    checkOutput("total rejects", rejects_seen, exp_rejects);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
